ahb_subordinate_sram: RTL

//   AHB subordinate (target end of the bus driven by our AHB manager) fronting a flop-based SRAM.

---
 rtl/ahb_subordinate_sram.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ahb_subordinate_sram.sv
// AHB subordinate in front of a flop-based SRAM, with programmable wait states
// and two-cycle ERROR/RETRY responses (RETRY forceable from a sideband input).
package ahb_manager_pack;
    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } t_htrans;

    typedef enum logic [2:0] {
        SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_DWORD,
        SIZE_4WORD, SIZE_8WORD, SIZE_16WORD, SIZE_32WORD
    } t_hsize;

    typedef enum logic [2:0] {
        BURST_SINGLE, BURST_INCR, BURST_WRAP4, BURST_INCR4,
        BURST_WRAP8, BURST_INCR8, BURST_WRAP16, BURST_INCR16
    } t_hburst;

    typedef enum logic [1:0] {
        RESP_OKAY, RESP_ERROR, RESP_RETRY, RESP_SPLIT
    } t_hresp;
endpackage

module ahb_subordinate_sram
    import ahb_manager_pack::*;
#(
    parameter int          DATA_WDT    = 32,
    parameter int          DEPTH       = 256,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic                i_hclk,
    input  logic                i_hreset_n,
    input  logic                i_hsel,
    input  logic [31:0]         i_haddr,
    input  t_htrans             i_htrans,
    input  logic                i_hwrite,
    input  t_hsize              i_hsize,
    input  t_hburst             i_hburst,
    input  logic [DATA_WDT-1:0] i_hwdata,
    input  logic                i_hready,
    input  logic                i_retry_req,
    output logic                o_hready,
    output t_hresp              o_hresp,
    output logic [DATA_WDT-1:0] o_hrdata,
    output logic [15:0]         o_err_cnt
);
    localparam int          BYTES     = DATA_WDT / 8;
    localparam int          OFS       = $clog2(BYTES);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] SPAN      = 32'(DEPTH * BYTES);
    localparam logic [2:0]  MAX_SIZE  = 3'(OFS);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DONE, ST_RESP1, ST_RESP2} t_state;

    t_state              state_q, state_d;
    logic [3:0]          wait_q, wait_d;
    logic [AW-1:0]       word_q;
    logic [OFS-1:0]      off_q;
    logic [2:0]          size_q;
    logic                write_q;
    logic                dphase_q;
    t_hresp              resp_q;
    logic [15:0]         err_cnt_q;
    logic [DATA_WDT-1:0] mem [DEPTH];

    logic                open_phase, accept, out_of_range, size_bad, misaligned;
    logic                bad, fault, complete, unused_burst;
    logic [2:0]          size_in;
    logic [31:0]         offset, align_mask;
    logic [BYTES-1:0]    byte_en;

    // Addresses below BASE_ADDR wrap to a huge offset, so one compare covers both ends.
    assign size_in      = i_hsize;
    assign offset       = i_haddr - BASE_ADDR;
    assign out_of_range = offset >= SPAN;
    assign size_bad     = size_in > MAX_SIZE;
    assign align_mask   = (32'd1 << size_in) - 32'd1;
    assign misaligned   = |(i_haddr & align_mask);
    assign bad          = out_of_range | size_bad | misaligned;
    assign fault        = bad | i_retry_req;
    assign unused_burst = ^i_hburst;

    assign open_phase = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_RESP2);
    assign accept     = open_phase & i_hsel & i_hready &
                        ((i_htrans == TRANS_NONSEQ) || (i_htrans == TRANS_SEQ));
    assign complete   = dphase_q & ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_WAIT: begin
                wait_d = wait_q - 4'd1;
                if (wait_q == 4'd1) state_d = ST_DONE;
            end
            ST_RESP1: state_d = ST_RESP2;
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (fault) begin
                        state_d = ST_RESP1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        wait_d  = WAIT_LOAD;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            dphase_q  <= 1'b0;
            write_q   <= 1'b0;
            word_q    <= '0;
            off_q     <= '0;
            size_q    <= '0;
            resp_q    <= RESP_OKAY;
            err_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (open_phase) dphase_q <= accept & ~fault;
            if (accept) begin
                word_q  <= i_haddr[OFS +: AW];
                off_q   <= i_haddr[OFS-1:0];
                size_q  <= size_in;
                write_q <= i_hwrite;
                resp_q  <= bad ? RESP_ERROR : (i_retry_req ? RESP_RETRY : RESP_OKAY);
                if (bad && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    // Little-endian lane enables for the registered offset and size.
    always_comb begin
        byte_en = '0;
        for (int b = 0; b < BYTES; b++) begin
            byte_en[b] = (b >= int'(off_q)) && (b < int'(off_q) + (1 << size_q));
        end
    end

    always_ff @(posedge i_hclk) begin
        if (complete && write_q) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byte_en[b]) mem[word_q][8*b +: 8] <= i_hwdata[8*b +: 8];
            end
        end
    end

    assign o_hready  = !((state_q == ST_WAIT) || (state_q == ST_RESP1));
    assign o_hresp   = ((state_q == ST_RESP1) || (state_q == ST_RESP2)) ? resp_q : RESP_OKAY;
    assign o_hrdata  = (complete && !write_q) ? mem[word_q] : '0;
    assign o_err_cnt = err_cnt_q;
endmodule
